// File: rtl/d_fifo_reader.sv
// Consumer side of the D0/D1 destination FIFOs: round-robin pop, single tagged
// output stream, routing-bit check and per-destination word counters.
//
// state | meaning
// IDLE  | writer inactive, nothing to drain
// RUN   | writer active, popping whenever downstream is ready
// DRAIN | writer went inactive, emptying whatever is left in D0/D1
// ERROR | writer error or misrouted word seen; frozen until reset
module d_fifo_reader #(
  parameter int data_width  = 6,
  parameter int dest_bit    = 4,
  parameter int count_width = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [data_width-1:0]  data_out_D0,
  input  logic [data_width-1:0]  data_out_D1,
  input  logic                   empty_fifo_D0,
  input  logic                   empty_fifo_D1,
  input  logic                   active_in,
  input  logic                   error_in,
  input  logic                   ready_in,
  output logic                   D0_pop,
  output logic                   D1_pop,
  output logic [data_width-1:0]  data_out,
  output logic                   valid_out,
  output logic                   src_out,
  output logic [count_width-1:0] cnt_D0,
  output logic [count_width-1:0] cnt_D1,
  output logic [1:0]             state_out,
  output logic                   idle_out,
  output logic                   error_out
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] ERROR = 2'd3;

  localparam logic [count_width-1:0] CNT_ONE = count_width'(1);

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic                  last_grant;
  logic                  grant;
  logic                  pop_ok;
  logic                  route_err;
  logic [data_width-1:0] head;

  // error_in gates the pop combinationally so an error cycle never consumes a word
  always_comb begin
    pop_ok = reset && ((state == RUN) || (state == DRAIN)) && ready_in && !error_in &&
             !(empty_fifo_D0 && empty_fifo_D1);
    if (!empty_fifo_D0 && !empty_fifo_D1)
      grant = ~last_grant;
    else
      grant = empty_fifo_D0;
    head      = grant ? data_out_D1 : data_out_D0;
    route_err = pop_ok && (head[dest_bit] != grant);
  end

  assign D0_pop = pop_ok && !grant;
  assign D1_pop = pop_ok && grant;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (active_in) state_nxt = RUN;
      RUN: begin
        if (error_in || route_err) state_nxt = ERROR;
        else if (!active_in)       state_nxt = DRAIN;
      end
      DRAIN: begin
        if (error_in || route_err) state_nxt = ERROR;
        else if (active_in)        state_nxt = RUN;
        else if (empty_fifo_D0 && empty_fifo_D1 && !pop_ok) state_nxt = IDLE;
      end
      default: state_nxt = ERROR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      data_out   <= '0;
      valid_out  <= 1'b0;
      src_out    <= 1'b0;
      cnt_D0     <= '0;
      cnt_D1     <= '0;
      last_grant <= 1'b1;
    end else begin
      state     <= state_nxt;
      valid_out <= pop_ok;
      if (pop_ok) begin
        data_out   <= head;
        src_out    <= grant;
        last_grant <= grant;
        if (grant) cnt_D1 <= cnt_D1 + CNT_ONE;
        else       cnt_D0 <= cnt_D0 + CNT_ONE;
      end
    end
  end

  assign state_out = state;
  assign idle_out  = (state == IDLE);
  assign error_out = (state == ERROR);

endmodule

// File: tb/tb_d_fifo_reader.sv
// Self-checking bench for d_fifo_reader: FIFO contents live in queues and a
// rule-level reference model predicts pops, output words, counters and state.
module tb_d_fifo_reader;

  localparam int DW = 6;
  localparam int DB = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] data_out_D0 = '0, data_out_D1 = '0;
  logic          empty_fifo_D0 = 1'b1, empty_fifo_D1 = 1'b1;
  logic          active_in = 1'b0, error_in = 1'b0, ready_in = 1'b0;
  logic          D0_pop, D1_pop;
  logic [DW-1:0] data_out;
  logic          valid_out, src_out;
  logic [CW-1:0] cnt_D0, cnt_D1;
  logic [1:0]    state_out;
  logic          idle_out, error_out;

  d_fifo_reader #(.data_width(DW), .dest_bit(DB), .count_width(CW)) dut (
    .clk(clk), .reset(reset),
    .data_out_D0(data_out_D0), .data_out_D1(data_out_D1),
    .empty_fifo_D0(empty_fifo_D0), .empty_fifo_D1(empty_fifo_D1),
    .active_in(active_in), .error_in(error_in), .ready_in(ready_in),
    .D0_pop(D0_pop), .D1_pop(D1_pop),
    .data_out(data_out), .valid_out(valid_out), .src_out(src_out),
    .cnt_D0(cnt_D0), .cnt_D1(cnt_D1),
    .state_out(state_out), .idle_out(idle_out), .error_out(error_out)
  );

  always #5 clk = ~clk;

  int comps = 0;
  int errs  = 0;

  // FIFO contents and reference model state
  logic [DW-1:0] q0[$], q1[$], got[$];
  logic [1:0]    m_state = 2'd0;
  logic          m_last = 1'b1, m_valid = 1'b0, m_src = 1'b0;
  logic [DW-1:0] m_data = '0;
  logic [CW-1:0] m_cnt0 = '0, m_cnt1 = '0;
  logic          exp_p0, exp_p1, obs_p0, obs_p1;

  task automatic drive_fifos();
    empty_fifo_D0 = (q0.size() == 0);
    empty_fifo_D1 = (q1.size() == 0);
    data_out_D0   = (q0.size() != 0) ? q0[0] : '0;
    data_out_D1   = (q1.size() != 0) ? q1[0] : '0;
  endtask

  // Entered and left at a falling edge; samples pops before the rising edge.
  task automatic tick();
    bit n0, n1, can, g, pre_empty, rerr;
    logic [DW-1:0] w;
    drive_fifos();
    #1;
    n0  = (q0.size() != 0);
    n1  = (q1.size() != 0);
    can = reset && (m_state == 2'd1 || m_state == 2'd2) && ready_in && !error_in && (n0 || n1);
    g   = (n0 && n1) ? !m_last : n1;
    exp_p0 = can && !g;
    exp_p1 = can && g;
    obs_p0 = D0_pop;
    obs_p1 = D1_pop;
    @(posedge clk);
    if (!reset) begin
      m_state = 2'd0; m_last = 1'b1; m_valid = 1'b0; m_src = 1'b0;
      m_data = '0; m_cnt0 = '0; m_cnt1 = '0;
    end else begin
      pre_empty = !n0 && !n1;
      rerr = 1'b0;
      m_valid = can;
      if (can) begin
        w = g ? q1.pop_front() : q0.pop_front();
        m_data = w; m_src = g; m_last = g;
        if (g) m_cnt1 = m_cnt1 + 1'b1; else m_cnt0 = m_cnt0 + 1'b1;
        rerr = (w[DB] != g);
      end
      case (m_state)
        2'd0: if (active_in) m_state = 2'd1;
        2'd1: if (error_in || rerr) m_state = 2'd3; else if (!active_in) m_state = 2'd2;
        2'd2: if (error_in || rerr) m_state = 2'd3; else if (active_in) m_state = 2'd1;
              else if (pre_empty && !can) m_state = 2'd0;
        default: m_state = 2'd3;
      endcase
    end
    #1;
    drive_fifos();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b0; active_in = 1'b0; error_in = 1'b0; ready_in = 1'b0;
    q0.delete(); q1.delete(); got.delete();
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; active_in = 1'b0; ready_in = 1'b1;
    q0.delete(); q1.delete();
    for (int i = 0; i < 3; i++) begin
      tick();
      comps += 2;
      if ({obs_p0, obs_p1} !== 2'b00) begin
        errs++; $display("FAIL reset_pops got %b%b want 00", obs_p0, obs_p1);
      end
      if ({data_out, valid_out, src_out, cnt_D0, cnt_D1, state_out, idle_out, error_out} !==
          {6'd0, 1'b0, 1'b0, 8'd0, 8'd0, 2'd0, 1'b1, 1'b0}) begin
        errs++; $display("FAIL reset_outputs got %h/%b/%b/%0d/%0d/%0d/%b/%b want all 0, idle=1",
                         data_out, valid_out, src_out, cnt_D0, cnt_D1, state_out, idle_out, error_out);
      end
    end
    reset = 1'b1;
    q0.push_back(6'b000001); q0.push_back(6'b000010);
    for (int i = 0; i < 3; i++) begin
      tick();
      comps += 2;
      if ({obs_p0, obs_p1} !== 2'b00) begin
        errs++; $display("FAIL idle_pops got %b%b want 00", obs_p0, obs_p1);
      end
      if ({valid_out, cnt_D0, state_out, idle_out} !== {1'b0, 8'd0, 2'd0, 1'b1}) begin
        errs++; $display("FAIL idle_state got v=%b c=%0d s=%0d i=%b want v=0 c=0 s=0 i=1",
                         valid_out, cnt_D0, state_out, idle_out);
      end
    end
  endtask

  task automatic test_single_stream();
    logic [DW-1:0] want[3];
    want[0] = 6'b000100; want[1] = 6'b000101; want[2] = 6'b000110;
    apply_reset();
    active_in = 1'b1; ready_in = 1'b1;
    for (int i = 0; i < 3; i++) q0.push_back(want[i]);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (valid_out) got.push_back(data_out);
      comps += 3;
      if ({obs_p0, obs_p1} !== {exp_p0, exp_p1}) begin
        errs++; $display("FAIL single_pops cyc %0d got %b%b want %b%b", i, obs_p0, obs_p1, exp_p0, exp_p1);
      end
      if ({valid_out, src_out, data_out} !== {m_valid, m_src, m_data}) begin
        errs++; $display("FAIL single_word cyc %0d got %b/%b/%h want %b/%b/%h",
                         i, valid_out, src_out, data_out, m_valid, m_src, m_data);
      end
      if ({state_out, cnt_D0, cnt_D1} !== {m_state, m_cnt0, m_cnt1}) begin
        errs++; $display("FAIL single_state cyc %0d got %0d/%0d/%0d want %0d/%0d/%0d",
                         i, state_out, cnt_D0, cnt_D1, m_state, m_cnt0, m_cnt1);
      end
    end
    comps++;
    if (got.size() != 3 || cnt_D0 !== 8'd3) begin
      errs++; $display("FAIL single_total got %0d words cnt=%0d want 3 words cnt=3", got.size(), cnt_D0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        comps++;
        if (got[i] !== want[i]) begin
          errs++; $display("FAIL single_order idx %0d got %b want %b", i, got[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [DW-1:0] want[4];
    want[0] = 6'b000101; want[1] = 6'b010101; want[2] = 6'b000110; want[3] = 6'b011110;
    apply_reset();
    active_in = 1'b1; ready_in = 1'b1;
    q0.push_back(want[0]); q0.push_back(want[2]);
    q1.push_back(want[1]); q1.push_back(want[3]);
    for (int i = 0; i < 8; i++) begin
      ready_in = (i == 2 || i == 3) ? 1'b0 : 1'b1;
      tick();
      if (valid_out) got.push_back(data_out);
      comps += 3;
      if ({obs_p0, obs_p1} !== {exp_p0, exp_p1}) begin
        errs++; $display("FAIL rr_pops cyc %0d got %b%b want %b%b", i, obs_p0, obs_p1, exp_p0, exp_p1);
      end
      if ({valid_out, src_out, data_out} !== {m_valid, m_src, m_data}) begin
        errs++; $display("FAIL rr_word cyc %0d got %b/%b/%h want %b/%b/%h",
                         i, valid_out, src_out, data_out, m_valid, m_src, m_data);
      end
      if ({state_out, cnt_D0, cnt_D1} !== {m_state, m_cnt0, m_cnt1}) begin
        errs++; $display("FAIL rr_state cyc %0d got %0d/%0d/%0d want %0d/%0d/%0d",
                         i, state_out, cnt_D0, cnt_D1, m_state, m_cnt0, m_cnt1);
      end
      if (!ready_in) begin
        comps++;
        if ({obs_p0, obs_p1, valid_out} !== 3'b000) begin
          errs++; $display("FAIL backpressure cyc %0d got pops=%b%b valid=%b want 000", i, obs_p0, obs_p1, valid_out);
        end
      end
    end
    comps++;
    if (got.size() != 4 || cnt_D0 !== 8'd2 || cnt_D1 !== 8'd2) begin
      errs++; $display("FAIL rr_total got %0d words c0=%0d c1=%0d want 4 words c0=2 c1=2", got.size(), cnt_D0, cnt_D1);
    end else begin
      for (int i = 0; i < 4; i++) begin
        comps++;
        if (got[i] !== want[i]) begin
          errs++; $display("FAIL rr_order idx %0d got %b want %b", i, got[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_drain();
    bit saw_drain = 0;
    got.delete();
    q1.push_back(6'b010001); q1.push_back(6'b011010);
    active_in = 1'b0; ready_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (valid_out) got.push_back(data_out);
      if (state_out == 2'd2) saw_drain = 1;
      comps += 2;
      if ({obs_p0, obs_p1} !== {exp_p0, exp_p1}) begin
        errs++; $display("FAIL drain_pops cyc %0d got %b%b want %b%b", i, obs_p0, obs_p1, exp_p0, exp_p1);
      end
      if ({valid_out, src_out, data_out, state_out, cnt_D1} !== {m_valid, m_src, m_data, m_state, m_cnt1}) begin
        errs++; $display("FAIL drain_out cyc %0d got %b/%b/%h/%0d/%0d want %b/%b/%h/%0d/%0d", i,
                         valid_out, src_out, data_out, state_out, cnt_D1, m_valid, m_src, m_data, m_state, m_cnt1);
      end
    end
    comps++;
    if (!saw_drain || state_out !== 2'd0 || got.size() != 2 || idle_out !== 1'b1) begin
      errs++; $display("FAIL drain_end got drain_seen=%0d state=%0d words=%0d want 1/0/2", saw_drain, state_out, got.size());
    end
  endtask

  task automatic test_route_error();
    apply_reset();
    active_in = 1'b1; ready_in = 1'b1;
    q0.push_back(6'b010010);
    tick(); tick();
    comps++;
    if ({valid_out, src_out, data_out, state_out, error_out, cnt_D0} !== {1'b1, 1'b0, 6'b010010, 2'd3, 1'b1, 8'd1}) begin
      errs++; $display("FAIL route_err got v=%b s=%b d=%b st=%0d e=%b c0=%0d want 1/0/010010/3/1/1",
                       valid_out, src_out, data_out, state_out, error_out, cnt_D0);
    end
    q0.push_back(6'b000011); q1.push_back(6'b010011);
    for (int i = 0; i < 3; i++) begin
      tick();
      comps++;
      if ({obs_p0, obs_p1, valid_out, state_out, cnt_D0, cnt_D1} !== {3'b000, 2'd3, 8'd1, 8'd0}) begin
        errs++; $display("FAIL route_frozen cyc %0d got pops=%b%b v=%b st=%0d c=%0d/%0d want 00/0/3/1/0",
                         i, obs_p0, obs_p1, valid_out, state_out, cnt_D0, cnt_D1);
      end
    end
  endtask

  task automatic test_wrap();
    int words = 0;
    logic [DW-1:0] w;
    apply_reset();
    active_in = 1'b1; ready_in = 1'b1;
    for (int i = 0; i < 256; i++) begin
      w = DW'($urandom_range(0, 63)); w[DB] = 1'b1;
      q1.push_back(w);
    end
    for (int i = 0; i < 259; i++) begin
      tick();
      if (valid_out) words++;
      comps += 2;
      if ({obs_p0, obs_p1} !== {exp_p0, exp_p1}) begin
        errs++; $display("FAIL wrap_pops cyc %0d got %b%b want %b%b", i, obs_p0, obs_p1, exp_p0, exp_p1);
      end
      if ({valid_out, data_out, state_out, cnt_D1} !== {m_valid, m_data, m_state, m_cnt1}) begin
        errs++; $display("FAIL wrap_out cyc %0d got %b/%h/%0d/%0d want %b/%h/%0d/%0d", i,
                         valid_out, data_out, state_out, cnt_D1, m_valid, m_data, m_state, m_cnt1);
      end
    end
    comps++;
    if (words != 256 || cnt_D1 !== 8'd0 || cnt_D0 !== 8'd0) begin
      errs++; $display("FAIL wrap_total got %0d words c1=%0d want 256 words c1=0", words, cnt_D1);
    end
  endtask

  task automatic test_error_priority();
    apply_reset();
    active_in = 1'b1; ready_in = 1'b1;
    tick();
    q0.push_back(6'b000111);
    error_in = 1'b1;
    tick();
    error_in = 1'b0;
    comps++;
    if ({obs_p0, obs_p1, valid_out, state_out, error_out, cnt_D0} !== {3'b000, 2'd3, 1'b1, 8'd0}) begin
      errs++; $display("FAIL err_priority got pops=%b%b v=%b st=%0d e=%b c0=%0d want 00/0/3/1/0",
                       obs_p0, obs_p1, valid_out, state_out, error_out, cnt_D0);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] w;
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      active_in = ($urandom_range(0, 15) != 0);
      ready_in  = ($urandom_range(0, 3) != 0);
      if (q0.size() < 6 && $urandom_range(0, 1)) begin
        w = DW'($urandom_range(0, 63)); w[DB] = 1'b0; q0.push_back(w);
      end
      if (q1.size() < 6 && $urandom_range(0, 2) == 0) begin
        w = DW'($urandom_range(0, 63)); w[DB] = 1'b1; q1.push_back(w);
      end
      tick();
      comps += 3;
      if ({obs_p0, obs_p1} !== {exp_p0, exp_p1}) begin
        errs++; $display("FAIL rand_pops cyc %0d got %b%b want %b%b", i, obs_p0, obs_p1, exp_p0, exp_p1);
      end
      if ({valid_out, src_out, data_out} !== {m_valid, m_src, m_data}) begin
        errs++; $display("FAIL rand_word cyc %0d got %b/%b/%h want %b/%b/%h",
                         i, valid_out, src_out, data_out, m_valid, m_src, m_data);
      end
      if ({state_out, idle_out, error_out, cnt_D0, cnt_D1} !==
          {m_state, m_state == 2'd0, m_state == 2'd3, m_cnt0, m_cnt1}) begin
        errs++; $display("FAIL rand_state cyc %0d got %0d/%b/%b/%0d/%0d want %0d/%0d/%0d",
                         i, state_out, idle_out, error_out, cnt_D0, cnt_D1, m_state, m_cnt0, m_cnt1);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_stream();
    test_round_robin();
    test_drain();
    test_route_error();
    test_wrap();
    test_error_priority();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, errs);
    $finish;
  end

endmodule
